// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame defaults and the transmit
// state encoding. Imported by the serializer and the future receiver.
package uart_pkg;

   localparam int PARITY_NONE   = 0;
   localparam int PARITY_ODD    = 1;
   localparam int PARITY_EVEN   = 2;

   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_STOP_BITS = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      PAR   = 3'd4,
      STOP  = 3'd5
   } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between an upstream producer and the UART serializer.
//   tx_data  : byte to send, sampled on handshake
//   tx_valid : producer has data
//   tx_ready : serializer can accept
// master = producer side, slave = serializer side.
interface uart_tx_serializer_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits. Bit timing from baud_tick.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   baud_tick : one-cycle strobe per bit period
//   bus       : byte handshake (slave side)
//   tx        : registered serial line, idles high
//   busy      : high while a frame is in progress
//   tx_done   : one-cycle pulse after the last stop bit
//
// state | meaning
// IDLE  | line high, waiting for a byte
// SYNC  | byte latched, waiting for the next tick to align the start edge
// START | start bit on the line
// DATA  | data bit bit_idx on the line
// PAR   | parity bit on the line
// STOP  | stop bit stop_cnt on the line
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int PARITY    = PARITY_NONE,
   parameter int STOP_BITS = DEF_STOP_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baud_tick,
   uart_tx_serializer_if.slave   bus,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_serializer: DATA_BITS must be 5..8");
   end
   if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end

   localparam logic [2:0] ST_IDLE  = IDLE;
   localparam logic [2:0] ST_SYNC  = SYNC;
   localparam logic [2:0] ST_START = START;
   localparam logic [2:0] ST_DATA  = DATA;
   localparam logic [2:0] ST_PAR   = PAR;
   localparam logic [2:0] ST_STOP  = STOP;

   localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   logic [2:0]           state;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic [2:0]           bit_idx;
   logic                 stop_cnt;

   assign bus.tx_ready = (state == ST_IDLE);
   assign busy         = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         par_bit  <= 1'b0;
         bit_idx  <= 3'd0;
         stop_cnt <= 1'b0;
         tx       <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (bus.tx_valid) begin
                  shreg   <= bus.tx_data;
                  par_bit <= (PARITY == PARITY_ODD) ? ~(^bus.tx_data) : (^bus.tx_data);
                  state   <= ST_SYNC;
               end
            end
            ST_SYNC: if (baud_tick) begin
               tx    <= 1'b0;
               state <= ST_START;
            end
            ST_START: if (baud_tick) begin
               tx      <= shreg[0];
               bit_idx <= 3'd0;
               state   <= ST_DATA;
            end
            ST_DATA: if (baud_tick) begin
               if (bit_idx != LAST_IDX) begin
                  // next bit is shreg[1] before the shift lands
                  tx      <= shreg[1];
                  shreg   <= shreg >> 1;
                  bit_idx <= bit_idx + 3'd1;
               end else if (PARITY != PARITY_NONE) begin
                  tx    <= par_bit;
                  state <= ST_PAR;
               end else begin
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= ST_STOP;
               end
            end
            ST_PAR: if (baud_tick) begin
               tx       <= 1'b1;
               stop_cnt <= 1'b0;
               state    <= ST_STOP;
            end
            ST_STOP: if (baud_tick) begin
               if (stop_cnt != LAST_STOP) begin
                  stop_cnt <= stop_cnt + 1'b1;
               end else begin
                  tx_done <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit serializer, downstream of the baud-rate generator. Accepts one byte per valid/ready handshake and shifts out a framed asynchronous serial character on tx: start bit, DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits. All bit timing comes from baud_tick, a one-clk-cycle strobe per bit period. The block runs entirely in the clk domain and uses no derived clocks.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock (100 MHz).
rst  in  1  reset; asynchronous, active-high.
baud_tick  in  1  single-cycle strobe, one per bit period (9.6 kHz rate at 100 MHz).
tx_data  in  DATA_BITS  byte to send; sampled only on handshake.
tx_valid  in  1  upstream has data.
tx_ready  out  1  block can accept; high only in IDLE.
tx  out  1  serial line; idles high; registered.
busy  out  1  high from acceptance until return to IDLE.
tx_done  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values (asynchronous): state IDLE, tx=1, busy=0, tx_done=0, shift register=0, counters=0. tx_ready=1 follows from IDLE.
- Handshake: transfer occurs when tx_valid && tx_ready on a rising clk edge. tx_data is latched into the shift register, parity is computed from the latched value, and state moves to SYNC. tx_data is ignored at all other times.
- tx_ready is a combinational decode of state==IDLE. It has no combinational path from tx_valid.
- States and transitions. All transitions except IDLE->SYNC occur only on a cycle with baud_tick=1.
  - IDLE: tx=1. Any baud_tick is ignored.
  - SYNC: tick -> tx<=0, go to START. Frame edges are aligned to ticks, so every bit lasts exactly one tick period.
  - START: tick -> tx<=d[0], bit_idx<=0, go to DATA.
  - DATA: tick with bit_idx<DATA_BITS-1 -> shift, tx<=next bit, bit_idx++. Tick with bit_idx==DATA_BITS-1 -> tx<=parity bit and go to PAR if PARITY!=0; otherwise tx<=1 and go to STOP.
  - PAR: tick -> tx<=1, stop_cnt<=0, go to STOP.
  - STOP: tick with stop_cnt<STOP_BITS-1 -> stop_cnt++. Tick with stop_cnt==STOP_BITS-1 -> go to IDLE and pulse tx_done for exactly one clk.
- Parity bit: even mode = XOR of the data bits; odd mode = inverted XOR.
- Latency: tx falls on the first baud_tick strictly after the acceptance cycle. A tick coincident with acceptance is not used.
- Frame length in ticks: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS, counted from the falling edge of the start bit.
- Back-to-back frames: tx_ready rises the cycle after the final stop tick. If tx_valid is held high, the next byte is accepted in that cycle, and its start bit begins at the following tick. Minimum idle between frames is therefore 0 extra ticks, and the stop bit is never shortened.
- busy = (state != IDLE).
- Reset mid-frame: tx returns to 1 immediately and the frame is aborted. tx_done is not pulsed. The next handshake starts a fresh frame.
- Counter widths: bit_idx uses 3 bits; stop_cnt uses 1 bit. Neither counter wraps in legal operation.
- Illegal parameter values (DATA_BITS outside 5..8, PARITY>2, STOP_BITS outside 1..2) are rejected by elaboration-time checks.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/PARITY_ODD/PARITY_EVEN constants.
  - The state enum: IDLE, SYNC, START, DATA, PAR, STOP.
  - Default DATA_BITS and STOP_BITS, reused by the future receiver.
- No sub-module: the FSM, shift register and parity logic stay in one module. baud_tick comes from the existing baud-rate generator, converted to a strobe at the top level.

Test Plan:
All scenarios use baud_tick every 16 clk in simulation.
- Reset then idle 100 clk with ticks -> tx=1, tx_ready=1, busy=0, tx_done=0 throughout.
- PARITY=0, STOP_BITS=1, send 0x55 -> tx reads 0,1,0,1,0,1,0,1,0,1 with each bit lasting 16 clk; tx_done pulses once, 10 ticks after the start edge.
- PARITY=2 (even), send 0x07 -> parity bit 1; with PARITY=1 (odd), send 0x07 -> parity bit 0. Frame is 11 ticks.
- STOP_BITS=2, tx_valid held high with 0xA3 then 0x3C -> each stop period is 2 ticks high; second start bit begins exactly 1 tick after the last stop tick. Bytes decode correctly and no bytes are lost or duplicated.
- tx_valid asserted in the same cycle as baud_tick -> accepted, but tx stays high until the next tick, 16 clk later.
- rst pulsed during data bit 4 of 0xFF -> tx=1 within the reset cycle, no tx_done pulse. A subsequent 0x81 transmits a complete, correct frame.
